por_button_conditioner: RTL and testbench
=========================================

// Module: por_button_conditioner
// PURPOSE
//   Board-level reset and input conditioning placed between PLL/pads and the core.
//   Builds a power-on reset from the PLL lock, restarts it on any lock loss, and
//   releases NUM_RST reset domains in order, STAGE_GAP cycles apart.
//   Also synchronises and debounces NUM_BTN async button pads into clean levels and press pulses.
// PARAMETERS
//   POR_CYCLES       1023    locked cycles required before the first release (>=1)
//   NUM_RST          2       number of staged reset outputs (>=1)
//   STAGE_GAP        16      cycles between successive rst_out releases (>=1)
//   NUM_BTN          4       button channels (>=1)
//   DEBOUNCE_CYCLES  250000  stable cycles before btn_level follows the pad (>=2); ~10 ms at 25.125 MHz
//   BTN_ACTIVE_LOW   1       1: pad low = pressed; 0: pad high = pressed
// PORTS
//   clk        in   1        system clock (PLL output)
//   rst        in   1        synchronous, active-high soft reset
//   locked     in   1        PLL lock, treated as async, synchronised internally (2 flops)
//   btn_raw    in   NUM_BTN  async button pads
//   rst_out    out  NUM_RST  active-high domain resets; bit 0 released first
//   ready      out  1        1 once every rst_out is released
//   btn_level  out  NUM_BTN  debounced level, 1 = pressed
//   btn_press  out  NUM_BTN  one-cycle pulse on a btn_level 0->1 edge
// BEHAVIOUR
//   Reset (rst=1 at an edge): FSM=WAIT_LOCK; rst_out=all 1; ready=0; btn_level=0; btn_press=0;
//     debounce counters=0; sync flops=0.
//   "locked" below always means the synchronised lock signal.
//   FSM states:
//     WAIT_LOCK: if locked, load por_cnt=POR_CYCLES and go to COUNT.
//     COUNT: por_cnt decrements by 1 each locked cycle.
//       When por_cnt==0, go to STAGE; rst_out[0] is 0 after that edge; load gap_cnt.
//     STAGE: rst_out[i] is released STAGE_GAP edges after rst_out[i-1].
//       After the last release, go to RUN on the same edge; ready=1 on that edge.
//       NUM_RST=1: go straight to RUN; ready rises with rst_out[0].
//     RUN: hold.
//   Lock loss (locked=0) in COUNT, STAGE or RUN: on the next edge, rst_out=all 1, ready=0,
//     FSM=WAIT_LOCK. The count fully restarts; there is no partial credit.
//   rst has priority over every FSM event on the same edge.
//   Counter widths: $clog2(POR_CYCLES+1), $clog2(STAGE_GAP+1), $clog2(DEBOUNCE_CYCLES+1).
//     No counter may wrap.
//   Debounce, per channel:
//     2-flop synchroniser, then polarity normalisation to p.
//     If p != btn_level: cnt++. If cnt reaches DEBOUNCE_CYCLES-1 on that edge,
//       btn_level<=p and cnt<=0.
//     If p == btn_level: cnt<=0. Any bounce restarts the count.
//     Latency from a stable pad change to btn_level: 2 sync + DEBOUNCE_CYCLES edges (+1 for async sampling).
//   btn_press: registered; high for 1 cycle on the edge after btn_level rises, and only while ready=1.
//     Presses completed while ready=0 are dropped, not queued.
//   Debouncers run during POR, so a button held at power-up shows btn_level=1 but gives no btn_press.
// CONFIGURATION
//   POR_LOCK_FILTER_EN defined:
//     Lock loss counts only after locked=0 for 4 consecutive cycles; reset asserts on the 4th low edge.
//     Shorter dips are ignored, and por_cnt keeps decrementing during them.
//   POR_LOCK_FILTER_EN undefined:
//     A single locked=0 cycle is a lock loss. No filter logic is present.
// TESTING
//   Bench params: POR_CYCLES=8, NUM_RST=2, STAGE_GAP=4, NUM_BTN=2, DEBOUNCE_CYCLES=5, BTN_ACTIVE_LOW=1.
//   Edge E0 = first edge where rst=0 and the synchronised locked=1.
//   1 Power-up, locked steady -> FSM enters COUNT at E0; rst_out[0]=0 after E9;
//     rst_out[1]=0 and ready=1 after E13.
//   2 locked dropped for 1 cycle at E5, macro off -> rst_out=2'b11 next edge;
//     after relock, rst_out[0] is released 9 edges later.
//   3 Lock loss in RUN -> rst_out=2'b11 and ready=0 next edge;
//     btn_press stays 0 through the whole re-POR, even if btn_level rises meanwhile.
//   4 btn_raw[0] toggling every 3 cycles -> btn_level[0] stays 0.
//     btn_raw[0] then held low -> btn_level[0]=1 within 8 edges; btn_press[0] high exactly 1 cycle.
//   5 rst=1 during STAGE (rst_out=2'b10) -> all outputs at reset values after that edge;
//     full POR sequence on rst release.
//   6 POR_LOCK_FILTER_EN, in RUN: locked low 3 cycles -> no reset;
//     locked low 4 cycles -> rst_out=2'b11 on the 4th low edge.

Source files
------------

// File: rtl/por_button_conditioner.sv
// por_button_conditioner: PLL-lock power-on reset with staged domain release, plus button sync/debounce.
// Optional POR_LOCK_FILTER_EN: lock loss only after 4 consecutive synchronised low cycles.
module por_button_conditioner #(
    parameter int POR_CYCLES      = 1023,
    parameter int NUM_RST         = 2,
    parameter int STAGE_GAP       = 16,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               locked,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press
);
    localparam int PW = $clog2(POR_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = NUM_RST > 1 ? $clog2(NUM_RST) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, STAGE, RUN} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      por_cnt, por_cnt_nxt;
    logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
    logic [SW-1:0]      stg, stg_nxt;
    logic [NUM_RST-1:0] rst_out_nxt;
    logic               ready_nxt;
    logic               lock_s1, lock_s2, lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= locked;
            lock_s2 <= lock_s1;
        end
    end

`ifdef POR_LOCK_FILTER_EN
    logic [1:0] low_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            low_cnt <= 2'd0;
        else
            low_cnt <= lock_s2 ? 2'd0 : (low_cnt == 2'd3 ? 2'd3 : low_cnt + 2'd1);
    end
    assign lost = !lock_s2 && low_cnt == 2'd3;
`else
    assign lost = !lock_s2;
`endif

    always_comb begin
        state_nxt   = state;
        por_cnt_nxt = por_cnt;
        gap_cnt_nxt = gap_cnt;
        stg_nxt     = stg;
        rst_out_nxt = rst_out;
        ready_nxt   = ready;
        if (state != WAIT_LOCK && lost) begin
            state_nxt   = WAIT_LOCK;
            rst_out_nxt = '1;
            ready_nxt   = 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s2) begin
                        state_nxt   = COUNT;
                        por_cnt_nxt = PW'(POR_CYCLES);
                    end
                end
                COUNT: begin
                    if (por_cnt == '0) begin
                        rst_out_nxt[0] = 1'b0;
                        gap_cnt_nxt    = GW'(STAGE_GAP - 1);
                        stg_nxt        = SW'(1);
                        state_nxt      = NUM_RST == 1 ? RUN : STAGE;
                        ready_nxt      = NUM_RST == 1;
                    end else begin
                        por_cnt_nxt = por_cnt - PW'(1);
                    end
                end
                STAGE: begin
                    if (gap_cnt == '0) begin
                        rst_out_nxt[stg] = 1'b0;
                        gap_cnt_nxt      = GW'(STAGE_GAP - 1);
                        if (stg == SW'(NUM_RST - 1)) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            stg_nxt = stg + SW'(1);
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt - GW'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            por_cnt <= '0;
            gap_cnt <= '0;
            stg     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            por_cnt <= por_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            stg     <= stg_nxt;
            rst_out <= rst_out_nxt;
            ready   <= ready_nxt;
        end
    end

    logic [NUM_BTN-1:0]         btn_s1, btn_s2, p, level_d, level_nxt;
    logic [NUM_BTN-1:0][DW-1:0] cnt, cnt_nxt;

    assign p = (BTN_ACTIVE_LOW != 0) ? ~btn_s2 : btn_s2;

    // Any sample agreeing with the current level restarts the stability count.
    always_comb begin
        for (int n = 0; n < NUM_BTN; n++) begin
            cnt_nxt[n]   = (p[n] == btn_level[n] || cnt[n] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt[n] + DW'(1);
            level_nxt[n] = (p[n] != btn_level[n] && cnt[n] == DW'(DEBOUNCE_CYCLES - 1)) ? p[n] : btn_level[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            cnt       <= '0;
            btn_level <= '0;
            level_d   <= '0;
            btn_press <= '0;
        end else begin
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
            level_d   <= btn_level;
            btn_press <= btn_level & ~level_d & {NUM_BTN{ready}};
        end
    end
endmodule

// File: tb/tb_por_button_conditioner.sv
// tb_por_button_conditioner: vector/scoreboard bench for por_button_conditioner (small parameters).
module tb_por_button_conditioner;
`ifdef POR_LOCK_FILTER_EN
    localparam int L = 4;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic [1:0] rst_out;
        logic       ready;
        logic [1:0] level;
        logic [1:0] press;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       locked;
        logic [1:0] btn;
        exp_t       e;
    } vec_t;

    logic       clk, rst, locked;
    logic [1:0] btn_raw, rst_out, btn_level, btn_press;
    logic       ready;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t pu[20];

    por_button_conditioner #(
        .POR_CYCLES(8), .NUM_RST(2), .STAGE_GAP(4),
        .NUM_BTN(2), .DEBOUNCE_CYCLES(5), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked), .btn_raw(btn_raw),
        .rst_out(rst_out), .ready(ready), .btn_level(btn_level), .btn_press(btn_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic lk, input logic [1:0] b,
                                input logic [1:0] ro, input logic rdy,
                                input logic [1:0] lv, input logic [1:0] pr);
        vec_t v;
        v.rst = r;
        v.locked = lk;
        v.btn = b;
        v.e.rst_out = ro;
        v.e.ready = rdy;
        v.e.level = lv;
        v.e.press = pr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        rst = v.rst;
        locked = v.locked;
        btn_raw = v.btn;
        sb.push_back(v.e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({nm, ".rst_out"}, rst_out, e.rst_out);
        chk({nm, ".ready"}, {1'b0, ready}, {1'b0, e.ready});
        chk({nm, ".level"}, btn_level, e.level);
        chk({nm, ".press"}, btn_press, e.press);
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        btn_raw = 2'b11;
        // Power-up after reset release: E0 is the 3rd edge (two sync flops first).
        for (int k = 1; k <= 20; k++)
            pu[k-1] = mk(1'b0, 1'b1, 2'b11, k < 12 ? 2'b11 : (k < 16 ? 2'b10 : 2'b00), k >= 16, 2'b00, 2'b00);

        step(mk(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00), "rst_a");
        step(mk(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00), "rst_b");
        for (int k = 0; k < 20; k++) step(pu[k], $sformatf("pwr[%0d]", k));

        for (int k = 0; k < 18; k++)
            step(mk(1'b0, 1'b1, {1'b1, ((k / 3) % 2) == 1}, 2'b00, 1'b1, 2'b00, 2'b00), $sformatf("bounce[%0d]", k));
        for (int j = 1; j <= 9; j++)
            step(mk(1'b0, 1'b1, 2'b10, 2'b00, 1'b1, {1'b0, j >= 7}, {1'b0, j == 8}), $sformatf("hold[%0d]", j));
        for (int j = 1; j <= 8; j++)
            step(mk(1'b0, 1'b1, 2'b11, 2'b00, 1'b1, {1'b0, j < 7}, 2'b00), $sformatf("relb0[%0d]", j));

`ifdef POR_LOCK_FILTER_EN
        for (int k = 1; k <= 10; k++)
            step(mk(1'b0, k > 3, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00), $sformatf("dip3[%0d]", k));
`endif

        // Lock loss in RUN with btn[1] pressed during the re-POR: level rises, press never.
        for (int k = 1; k <= L + 20; k++)
            step(mk(1'b0, k > L, 2'b01,
                    k < L + 2 ? 2'b00 : (k < L + 12 ? 2'b11 : (k < L + 16 ? 2'b10 : 2'b00)),
                    k < L + 2 || k >= L + 16, k >= 7 ? 2'b10 : 2'b00, 2'b00), $sformatf("loss[%0d]", k));
        for (int j = 1; j <= 8; j++)
            step(mk(1'b0, 1'b1, 2'b11, 2'b00, 1'b1, j < 7 ? 2'b10 : 2'b00, 2'b00), $sformatf("relb1[%0d]", j));

        step(mk(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00), "rst_c");
        for (int k = 0; k < 12; k++) step(pu[k], $sformatf("pre_stage[%0d]", k));
        step(mk(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00), "rst_stage");
        for (int k = 0; k < 20; k++) step(pu[k], $sformatf("repwr[%0d]", k));

`ifndef POR_LOCK_FILTER_EN
        // One-cycle drop seen by the FSM at E5; count restarts from the relock edge.
        step(mk(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00), "rst_d");
        for (int k = 1; k <= 24; k++)
            step(mk(1'b0, k != 6, 2'b11, k < 18 ? 2'b11 : (k < 22 ? 2'b10 : 2'b00), k >= 22, 2'b00, 2'b00),
                 $sformatf("cntloss[%0d]", k));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
